// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the reset sequencer.
// State encoding is also what the optional status output reports.
package reset_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        HOLD      = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int unsigned DEF_CHANNELS  = 3;
    localparam int unsigned DEF_CNT_W     = 21;
    localparam int unsigned DEF_DELAY     = 32'h0017_D796;
    localparam int unsigned DEF_STAGGER   = 16;
    localparam int unsigned DEF_LOCK_FILT = 4;
    localparam int unsigned DEF_DIVS      = 2;

    localparam int unsigned FILT_W = 8;
    localparam int unsigned LOSS_W = 8;

    // Saturating increment used by the restart counter.
    function automatic logic [LOSS_W-1:0] sat_inc(input logic [LOSS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/reset_seq_sync2.sv
// Two-flop synchroniser with a configurable reset value.
module sync2 #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    // Double register the asynchronous input into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/reset_seq.sv
// Power-on reset sequencer: qualifies PLL lock, holds for a fixed delay,
// then releases per-domain resets in ascending staggered order.
// Also produces free-running clock enables from a small divider.
// Optional build macro RESET_SEQ_STATUS_EN adds state_o and loss_cnt outputs.
module reset_seq
    import reset_seq_pkg::*;
#(
    parameter int unsigned CHANNELS  = DEF_CHANNELS,
    parameter int unsigned CNT_W     = DEF_CNT_W,
    parameter int unsigned DELAY     = DEF_DELAY,
    parameter int unsigned STAGGER   = DEF_STAGGER,
    parameter int unsigned LOCK_FILT = DEF_LOCK_FILT,
    parameter int unsigned DIVS      = DEF_DIVS
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                locked,
    input  logic                soft_reset,
    output logic [CHANNELS-1:0] user_reset,
    output logic                ready,
    output logic [DIVS-1:0]     ce
`ifdef RESET_SEQ_STATUS_EN
    ,
    output logic [1:0]          state_o,
    output logic [LOSS_W-1:0]   loss_cnt
`endif
);

    localparam logic [CNT_W-1:0]  DELAY_C     = CNT_W'(DELAY);
    localparam logic [CNT_W-1:0]  STAG_RELOAD = (STAGGER == 0) ? '0 : CNT_W'(STAGGER - 1);
    localparam logic [FILT_W-1:0] FILT_LAST   = FILT_W'(LOCK_FILT - 1);
    localparam bit                INSTANT     = (STAGGER == 0) || (CHANNELS == 1);

    logic                lock_s;
    state_t              state;
    logic [FILT_W-1:0]   filt;
    logic [CNT_W-1:0]    hold_cnt;
    logic [CNT_W-1:0]    stag_cnt;
    logic [DIVS-1:0]     div;
    logic [DIVS-1:0]     div_nxt;
    logic [DIVS-1:0]     ce_nxt;
    logic [CHANNELS-1:0] ur_shift;
    logic                restart;

    sync2 #(.RST_VAL(1'b0)) u_lock_sync (
        .clk   (clk),
        .rst_n (reset_n),
        .d     (locked),
        .q     (lock_s)
    );

    // Restart request: soft reset anywhere, or lock loss once past WAIT_LOCK.
    always_comb restart = soft_reset || (!lock_s && (state != WAIT_LOCK));

    // Releasing channels in ascending order is a left shift of the reset vector;
    // this also makes individual re-assertion structurally impossible.
    always_comb ur_shift = user_reset << 1;

    // Sequencer FSM with registered reset/ready outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= WAIT_LOCK;
            filt       <= '0;
            hold_cnt   <= DELAY_C;
            stag_cnt   <= '0;
            user_reset <= '1;
            ready      <= 1'b0;
        end else if (restart) begin
            state      <= WAIT_LOCK;
            filt       <= '0;
            stag_cnt   <= '0;
            user_reset <= '1;
            ready      <= 1'b0;
        end else begin
            unique case (state)
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        filt <= '0;
                    end else begin
                        filt <= filt + 1'b1;
                        if (filt == FILT_LAST) begin
                            state    <= HOLD;
                            hold_cnt <= DELAY_C;
                        end
                    end
                end
                HOLD: begin
                    if (hold_cnt == '0) begin
                        if (INSTANT) begin
                            user_reset <= '0;
                            ready      <= 1'b1;
                            state      <= RUN;
                        end else begin
                            user_reset <= ur_shift;
                            stag_cnt   <= STAG_RELOAD;
                            state      <= RELEASE;
                        end
                    end else begin
                        hold_cnt <= hold_cnt - 1'b1;
                    end
                end
                RELEASE: begin
                    if (stag_cnt == '0) begin
                        user_reset <= ur_shift;
                        stag_cnt   <= STAG_RELOAD;
                        if (ur_shift == '0) begin
                            state <= RUN;
                            ready <= 1'b1;
                        end
                    end else begin
                        stag_cnt <= stag_cnt - 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: state <= WAIT_LOCK;
            endcase
        end
    end

    // ce[k] needs div bits [k:0] all ones: isolate the lowest zero bit of the
    // next divider value, and the ones below it are exactly the active enables.
    always_comb begin
        div_nxt = div + DIVS'(1);
        ce_nxt  = (~div_nxt & (div_nxt + DIVS'(1))) - DIVS'(1);
    end

    // Free-running divider and registered clock enables, independent of state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div <= '0;
            ce  <= '0;
        end else begin
            div <= div_nxt;
            ce  <= ce_nxt;
        end
    end

`ifdef RESET_SEQ_STATUS_EN
    assign state_o = state;

    // Saturating count of restarts, cleared only by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            loss_cnt <= '0;
        end else if (restart) begin
            loss_cnt <= sat_inc(loss_cnt);
        end
    end
`endif

endmodule

// File: tb/tb_reset_seq.sv
// Self-checking bench for reset_seq: directed scenarios followed by random
// lock/soft-reset activity, checked against a lock-streak reference model.
module tb_reset_seq;

    localparam int CH   = 3;
    localparam int LF   = 3;
    localparam int DLY  = 8;
    localparam int STG  = 4;
    localparam int BASE = LF + DLY + 1;

    logic          clk;
    logic          reset_n;
    logic          locked;
    logic          soft_reset;
    logic [CH-1:0] ur_a, ur_b;
    logic          rdy_a, rdy_b;
    logic [1:0]    ce_a, ce_b;
`ifdef RESET_SEQ_STATUS_EN
    logic [1:0]    st_a, st_b;
    logic [7:0]    loss_a, loss_b;
`endif

    int tests = 0;
    int fails = 0;

    // Reference model: lock_s delay line, count of consecutive qualifying
    // edges (lock_s high, no soft reset), edges since reset, restart count.
    bit m_s1, m_s2;
    int m_n;
    int m_c;
    int m_loss;

    reset_seq #(
        .CHANNELS(CH), .CNT_W(21), .DELAY(DLY), .STAGGER(STG), .LOCK_FILT(LF), .DIVS(2)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .locked(locked), .soft_reset(soft_reset),
        .user_reset(ur_a), .ready(rdy_a), .ce(ce_a)
`ifdef RESET_SEQ_STATUS_EN
        , .state_o(st_a), .loss_cnt(loss_a)
`endif
    );

    reset_seq #(
        .CHANNELS(CH), .CNT_W(21), .DELAY(DLY), .STAGGER(0), .LOCK_FILT(LF), .DIVS(2)
    ) u_flat (
        .clk(clk), .reset_n(reset_n), .locked(locked), .soft_reset(soft_reset),
        .user_reset(ur_b), .ready(rdy_b), .ce(ce_b)
`ifdef RESET_SEQ_STATUS_EN
        , .state_o(st_b), .loss_cnt(loss_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [CH-1:0] exp_ur(input int n, input int stag);
        logic [CH-1:0] r;
        for (int k = 0; k < CH; k++) r[k] = (n >= BASE + stag * k) ? 1'b0 : 1'b1;
        return r;
    endfunction

    function automatic logic exp_rdy(input int n, input int stag);
        return (n >= BASE + stag * (CH - 1));
    endfunction

    function automatic logic [1:0] exp_ce(input int c);
        logic [1:0] r;
        for (int k = 0; k < 2; k++) r[k] = ((c % (2 << k)) == ((2 << k) - 1));
        return r;
    endfunction

    function automatic logic [1:0] exp_state(input int n, input int stag);
        if (n < LF) return 2'd0;
        if (n < BASE) return 2'd1;
        if (n < BASE + stag * (CH - 1)) return 2'd2;
        return 2'd3;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".ur_a"},  8'(ur_a),  8'(exp_ur(m_n, STG)));
        chk({tag, ".rdy_a"}, 8'(rdy_a), 8'(exp_rdy(m_n, STG)));
        chk({tag, ".ce_a"},  8'(ce_a),  8'(exp_ce(m_c)));
        chk({tag, ".ur_b"},  8'(ur_b),  8'(exp_ur(m_n, 0)));
        chk({tag, ".rdy_b"}, 8'(rdy_b), 8'(exp_rdy(m_n, 0)));
        chk({tag, ".ce_b"},  8'(ce_b),  8'(exp_ce(m_c)));
`ifdef RESET_SEQ_STATUS_EN
        chk({tag, ".st_a"},   8'(st_a),   8'(exp_state(m_n, STG)));
        chk({tag, ".st_b"},   8'(st_b),   8'(exp_state(m_n, 0)));
        chk({tag, ".loss_a"}, loss_a, 8'(m_loss));
        chk({tag, ".loss_b"}, loss_b, 8'(m_loss));
`endif
    endtask

    task automatic model_reset();
        m_s1 = 1'b0; m_s2 = 1'b0; m_n = 0; m_c = 0; m_loss = 0;
    endtask

    // One clock edge: advance the model with the inputs seen at the edge,
    // then check all outputs 1 time unit later.
    task automatic tick(input string tag);
        bit lk, sr, ls, rn;
        lk = locked; sr = soft_reset; rn = reset_n;
        @(posedge clk);
        if (rn) begin
            ls = m_s2;
            if (sr || (!ls && m_n >= LF)) m_loss = (m_loss < 255) ? m_loss + 1 : 255;
            m_s2 = m_s1;
            m_s1 = lk;
            m_n  = (ls && !sr) ? m_n + 1 : 0;
            m_c++;
        end
        #1;
        check_all(tag);
    endtask

    task automatic ticks(input string tag, input int k);
        for (int i = 0; i < k; i++) tick(tag);
    endtask

    initial begin
        reset_n = 1'b1; locked = 1'b0; soft_reset = 1'b0;
        model_reset();
        #1 reset_n = 1'b0;
        #1 check_all("reset_async");
        chk("reset_ur_const", 8'(ur_a), 8'h07);
        ticks("reset_hold", 2);
        reset_n = 1'b1;
        ticks("idle", 4);

        // Locked rises at cycle 0: releases at 14/18/22, flat instance at 14.
        locked = 1'b1;
        ticks("seq", 13);
        chk("seq13_ur", 8'(ur_a), 8'h07);
        tick("seq");
        chk("seq14_ur", 8'(ur_a), 8'h06);
        chk("seq14_flat_ur", 8'(ur_b), 8'h00);
        chk("seq14_flat_rdy", 8'(rdy_b), 8'h01);
        ticks("seq", 4);
        chk("seq18_ur", 8'(ur_a), 8'h04);
        ticks("seq", 3);
        chk("seq21_rdy", 8'(rdy_a), 8'h00);
        tick("seq");
        chk("seq22_ur", 8'(ur_a), 8'h00);
        chk("seq22_rdy", 8'(rdy_a), 8'h01);
        ticks("run", 5);

        // Lock loss in RUN: everything reasserted on the third edge.
        locked = 1'b0;
        ticks("loss", 2);
        chk("loss2_rdy", 8'(rdy_a), 8'h01);
        tick("loss");
        chk("loss3_ur", 8'(ur_a), 8'h07);
        chk("loss3_rdy", 8'(rdy_a), 8'h00);
        ticks("loss_idle", 4);

        // One-cycle glitch at cycle 3: release 14 cycles after it ends.
        locked = 1'b1;
        ticks("glitch", 3);
        locked = 1'b0;
        tick("glitch");
        locked = 1'b1;
        ticks("glitch", 13);
        chk("glitch13_ur", 8'(ur_a), 8'h07);
        tick("glitch");
        chk("glitch14_ur", 8'(ur_a), 8'h06);

        // Soft reset in RELEASE after channel 0: restart, then the same spacing.
        tick("soft_pre");
        soft_reset = 1'b1;
        tick("soft");
        soft_reset = 1'b0;
        chk("soft_ur", 8'(ur_a), 8'h07);
        chk("soft_rdy", 8'(rdy_a), 8'h00);
        ticks("soft_seq", 11);
        chk("soft11_ur", 8'(ur_a), 8'h07);
        tick("soft_seq");
        chk("soft12_ur", 8'(ur_a), 8'h06);
        ticks("soft_seq", 8);
        chk("soft20_ur", 8'(ur_a), 8'h00);
        chk("soft20_rdy", 8'(rdy_a), 8'h01);

        // Async reset mid-HOLD: outputs return without a clock edge.
        soft_reset = 1'b1;
        tick("hold_pre");
        soft_reset = 1'b0;
        ticks("hold", 6);
        #2 reset_n = 1'b0;
        model_reset();
        #1 check_all("hold_async");
        chk("hold_async_ce", 8'(ce_a), 8'h00);
        ticks("hold_rst", 2);
        reset_n = 1'b1;
        tick("ce");
        chk("ce1", 8'(ce_a), 8'h01);
        tick("ce");
        chk("ce2", 8'(ce_a), 8'h00);
        tick("ce");
        chk("ce3", 8'(ce_a), 8'h03);
        ticks("ce", 5);

        // Random lock behaviour and occasional soft resets.
        for (int i = 0; i < 3000; i++) begin
            if (locked) begin
                if ($urandom_range(0, 99) < 2) locked = 1'b0;
            end else begin
                if ($urandom_range(0, 99) < 12) locked = 1'b1;
            end
            soft_reset = ($urandom_range(0, 149) == 0);
            tick("rand");
        end
        soft_reset = 1'b0;

`ifdef RESET_SEQ_STATUS_EN
        for (int i = 0; i < 300; i++) begin
            soft_reset = 1'b1;
            tick("sat");
            soft_reset = 1'b0;
            tick("sat");
        end
        chk("loss_sat", loss_a, 8'hFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
